// File: rtl/gate_identifier_pkg.sv
// Shared definitions for the gate identifier: FSM states, gate codes and the
// reference truth tables. Bit i of a table is the gate output for {a,b} = i.
package gate_identifier_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    DONE
  } state_t;

  localparam logic [2:0] GATE_UNKNOWN = 3'd0;
  localparam logic [2:0] GATE_AND     = 3'd1;
  localparam logic [2:0] GATE_OR      = 3'd2;
  localparam logic [2:0] GATE_NAND    = 3'd3;
  localparam logic [2:0] GATE_NOR     = 3'd4;
  localparam logic [2:0] GATE_XOR     = 3'd5;
  localparam logic [2:0] GATE_NOT_A   = 3'd6;
  localparam logic [2:0] GATE_XNOR    = 3'd7;

  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_OR    = 4'b1110;
  localparam logic [3:0] TT_NAND  = 4'b0111;
  localparam logic [3:0] TT_NOR   = 4'b0001;
  localparam logic [3:0] TT_XOR   = 4'b0110;
  localparam logic [3:0] TT_NOT_A = 4'b0011;
  localparam logic [3:0] TT_XNOR  = 4'b1001;

  // The settle counter is 4 bits wide, so this is the longest hold it can express.
  localparam int unsigned SETTLE_MAX = 15;

endpackage

// File: rtl/gate_classifier.sv
// Combinational lookup from a sampled truth table to its gate code.
// A NOT gate whose inputs are both tied to probe_a shows up as NOT_A.
module gate_classifier
  import gate_identifier_pkg::*;
(
  input  logic [3:0] truth_table,
  output logic [2:0] gate_code
);

  // Exact match against the known tables; anything else is unknown.
  always_comb begin
    gate_code = GATE_UNKNOWN;
    case (truth_table)
      TT_AND:   gate_code = GATE_AND;
      TT_OR:    gate_code = GATE_OR;
      TT_NAND:  gate_code = GATE_NAND;
      TT_NOR:   gate_code = GATE_NOR;
      TT_XOR:   gate_code = GATE_XOR;
      TT_NOT_A: gate_code = GATE_NOT_A;
      TT_XNOR:  gate_code = GATE_XNOR;
      default:  gate_code = GATE_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/gate_identifier.sv
// Identifies an external two-input gate by walking {probe_a,probe_b} through
// 00,01,10,11, holding each vector SETTLE_CYCLES+1 cycles and sampling dut_out
// on the last edge of each hold. The finished table is classified on the edge
// that enters DONE and held until the next completed run.
module gate_identifier
  import gate_identifier_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       dut_out,
  output logic       probe_a,
  output logic       probe_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [2:0] gate_code,
  output logic       result_valid
);

  // A hold longer than the settle counter can count is a configuration error.
  generate
    if (SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
      $error("gate_identifier: SETTLE_CYCLES must be in 0..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_LAST = SETTLE_CYCLES[3:0];

  state_t     state;
  logic [1:0] index;
  logic [3:0] settle_cnt;
  logic [2:0] work_table;
  logic [3:0] final_table;
  logic [2:0] final_code;

  // Bit 3 is only ever needed at the final capture, so it comes straight from dut_out.
  assign final_table = {dut_out, work_table};

  gate_classifier u_classifier (
    .truth_table (final_table),
    .gate_code   (final_code)
  );

  // Single FSM: sequencing, probe drive, sampling and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      index        <= 2'd0;
      settle_cnt   <= 4'd0;
      work_table   <= 3'b000;
      probe_a      <= 1'b0;
      probe_b      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      truth_table  <= 4'b0000;
      gate_code    <= GATE_UNKNOWN;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          probe_a <= 1'b0;
          probe_b <= 1'b0;
          if (start) begin
            state      <= PROBE;
            index      <= 2'd0;
            settle_cnt <= 4'd0;
            work_table <= 3'b000;
            busy       <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end

        PROBE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            case (index)
              2'd0: work_table[0] <= dut_out;
              2'd1: work_table[1] <= dut_out;
              2'd2: work_table[2] <= dut_out;
              default: begin
                truth_table  <= final_table;
                gate_code    <= final_code;
                result_valid <= 1'b1;
              end
            endcase
            if (index == 2'd3) begin
              state   <= DONE;
              index   <= 2'd0;
              busy    <= 1'b0;
              done    <= 1'b1;
              probe_a <= 1'b0;
              probe_b <= 1'b0;
            end else begin
              index              <= index + 2'd1;
              {probe_a, probe_b} <= index + 2'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end

        DONE: begin
          state   <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          probe_a <= 1'b0;
          probe_b <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_identifier.sv
// Bench for gate_identifier: one instance with SETTLE_CYCLES=2 driving a gate
// model with a two-cycle propagation delay, one with SETTLE_CYCLES=0 for the
// held-start scenario. Expected tables and codes are queued when a run starts.
module tb_gate_identifier;

  localparam int SETTLE = 2;

  localparam int M_AND_FROM_NAND = 0;
  localparam int M_XOR           = 1;
  localparam int M_NOR           = 2;
  localparam int M_NOT_A         = 3;
  localparam int M_CONST1        = 4;
  localparam int M_XNOR          = 5;
  localparam int M_OR            = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       dut_out;
  logic       probe_a, probe_b, busy, done, result_valid;
  logic [3:0] truth_table;
  logic [2:0] gate_code;

  logic       start0 = 1'b0;
  logic       dut_out0;
  logic       probe_a0, probe_b0, busy0, done0, result_valid0;
  logic [3:0] truth_table0;
  logic [2:0] gate_code0;

  int         tb_mode = M_AND_FROM_NAND;
  int         tb_mode0 = M_OR;
  int         hold_cnt = 1000;
  logic [1:0] prev_probe = 2'b00;

  int         checks = 0;
  int         failures = 0;
  logic [6:0] sb[$];
  logic [6:0] sb0[$];

  always #5 clk = ~clk;

  gate_identifier #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start), .dut_out(dut_out),
    .probe_a(probe_a), .probe_b(probe_b), .busy(busy), .done(done),
    .truth_table(truth_table), .gate_code(gate_code), .result_valid(result_valid)
  );

  gate_identifier #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .dut_out(dut_out0),
    .probe_a(probe_a0), .probe_b(probe_b0), .busy(busy0), .done(done0),
    .truth_table(truth_table0), .gate_code(gate_code0), .result_valid(result_valid0)
  );

  function automatic logic gate_fn(input int mode, input logic a, input logic b);
    logic n;
    n = ~(a & b);
    case (mode)
      M_AND_FROM_NAND: gate_fn = ~(n & n);
      M_XOR:           gate_fn = a ^ b;
      M_NOR:           gate_fn = ~(a | b);
      M_NOT_A:         gate_fn = ~(a & a);
      M_CONST1:        gate_fn = 1'b1;
      M_XNOR:          gate_fn = ~(a ^ b);
      M_OR:            gate_fn = a | b;
      default:         gate_fn = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] model_table(input int mode);
    logic [3:0] t;
    logic [1:0] v;
    t = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      v = 2'(i);
      t[i] = gate_fn(mode, v[1], v[0]);
    end
    return t;
  endfunction

  // Count cycles since the probe vector last changed.
  always @(negedge clk) begin
    if ({probe_a, probe_b} != prev_probe) hold_cnt = 0;
    else if (hold_cnt < 1000) hold_cnt = hold_cnt + 1;
    prev_probe = {probe_a, probe_b};
  end

  // Gate output is inverted until the vector has been stable for SETTLE cycles.
  always_comb begin
    dut_out = gate_fn(tb_mode, probe_a, probe_b);
    if (hold_cnt < SETTLE) dut_out = ~dut_out;
  end

  always_comb dut_out0 = gate_fn(tb_mode0, probe_a0, probe_b0);

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Pulse start on the main instance and wait for done, counting edges.
  task automatic start_and_wait(output int lat, output bit timed_out, output int busy_gaps);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    timed_out = 1'b0;
    busy_gaps = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) busy_gaps++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({probe_a, probe_b} !== 2'b00) begin failures++; $display("[TB] FAIL reset_probes actual=%b required=00", {probe_a, probe_b}); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%b required=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done actual=%b required=0", done); end
    checks++; if (truth_table !== 4'b0000) begin failures++; $display("[TB] FAIL reset_table actual=%b required=0000", truth_table); end
    checks++; if (gate_code !== 3'd0) begin failures++; $display("[TB] FAIL reset_code actual=%0d required=0", gate_code); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid actual=%b required=0", result_valid); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_and();
    int lat; bit to; int gaps; logic [6:0] exp;
    tb_mode = M_AND_FROM_NAND;
    sb.push_back({model_table(M_AND_FROM_NAND), 3'd1});
    start_and_wait(lat, to, gaps);
    exp = sb.pop_front();
    checks++; if (to || lat != 4 * (SETTLE + 1)) begin failures++; $display("[TB] FAIL and_latency actual=%0d required=%0d", lat, 4 * (SETTLE + 1)); end
    checks++; if (gaps != 0) begin failures++; $display("[TB] FAIL and_busy actual=%0d_low_cycles required=0", gaps); end
    checks++; if (truth_table !== exp[6:3]) begin failures++; $display("[TB] FAIL and_table actual=%b required=%b", truth_table, exp[6:3]); end
    checks++; if (gate_code !== exp[2:0]) begin failures++; $display("[TB] FAIL and_code actual=%0d required=%0d", gate_code, exp[2:0]); end
    checks++; if (result_valid !== 1'b1) begin failures++; $display("[TB] FAIL and_valid actual=%b required=1", result_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL and_done_busy actual=%b required=0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL and_done_pulse actual=%b required=0", done); end
  endtask

  task automatic test_back_to_back();
    int lat; bit to; int gaps; logic [6:0] exp;
    tb_mode = M_XOR;
    sb.push_back({model_table(M_XOR), 3'd5});
    start_and_wait(lat, to, gaps);
    exp = sb.pop_front();
    checks++; if (to || truth_table !== exp[6:3] || gate_code !== exp[2:0]) begin failures++; $display("[TB] FAIL xor_result actual=%b/%0d required=%b/%0d", truth_table, gate_code, exp[6:3], exp[2:0]); end
    tb_mode = M_NOR;
    sb.push_back({model_table(M_NOR), 3'd4});
    start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_start_in_done actual=%b required=0", busy); end
    checks++; if (truth_table !== 4'b0110 || gate_code !== 3'd5) begin failures++; $display("[TB] FAIL b2b_hold_idle actual=%b/%0d required=0110/5", truth_table, gate_code); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_accept actual=%b required=1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 6) begin
        checks++; if (truth_table !== 4'b0110 || gate_code !== 3'd5 || result_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_hold_run actual=%b/%0d required=0110/5", truth_table, gate_code); end
      end
      @(negedge clk);
      lat++;
    end
    exp = sb.pop_front();
    checks++; if (lat != 4 * (SETTLE + 1)) begin failures++; $display("[TB] FAIL nor_latency actual=%0d required=%0d", lat, 4 * (SETTLE + 1)); end
    checks++; if (truth_table !== exp[6:3] || gate_code !== exp[2:0]) begin failures++; $display("[TB] FAIL nor_result actual=%b/%0d required=%b/%0d", truth_table, gate_code, exp[6:3], exp[2:0]); end
  endtask

  task automatic test_not_and_const();
    int lat; bit to; int gaps; logic [6:0] exp;
    tb_mode = M_NOT_A;
    sb.push_back({model_table(M_NOT_A), 3'd6});
    start_and_wait(lat, to, gaps);
    exp = sb.pop_front();
    checks++; if (to || truth_table !== exp[6:3] || gate_code !== exp[2:0]) begin failures++; $display("[TB] FAIL not_result actual=%b/%0d required=%b/%0d", truth_table, gate_code, exp[6:3], exp[2:0]); end
    tb_mode = M_CONST1;
    sb.push_back({model_table(M_CONST1), 3'd0});
    start_and_wait(lat, to, gaps);
    exp = sb.pop_front();
    checks++; if (to || truth_table !== exp[6:3] || gate_code !== exp[2:0]) begin failures++; $display("[TB] FAIL const1_result actual=%b/%0d required=%b/%0d", truth_table, gate_code, exp[6:3], exp[2:0]); end
  endtask

  task automatic test_start_held();
    bit exp_done, exp_busy;
    logic [6:0] exp;
    int n_done;
    n_done = 0;
    for (int k = 0; k < 4; k++) sb0.push_back({model_table(M_OR), 3'd2});
    @(negedge clk);
    start0 = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      exp_done = (n % 6 == 4) && (n <= 22);
      exp_busy = (n % 6 <= 3) && (n <= 21);
      checks++; if (done0 !== exp_done) begin failures++; $display("[TB] FAIL held_done_%0d actual=%b required=%b", n, done0, exp_done); end
      checks++; if (busy0 !== exp_busy) begin failures++; $display("[TB] FAIL held_busy_%0d actual=%b required=%b", n, busy0, exp_busy); end
      if (done0 === 1'b1 && sb0.size() > 0) begin
        exp = sb0.pop_front();
        n_done++;
        checks++; if (truth_table0 !== exp[6:3] || gate_code0 !== exp[2:0]) begin failures++; $display("[TB] FAIL held_result_%0d actual=%b/%0d required=%b/%0d", n, truth_table0, gate_code0, exp[6:3], exp[2:0]); end
      end
      if (n == 19) start0 = 1'b0;
    end
    checks++; if (n_done != 4) begin failures++; $display("[TB] FAIL held_run_count actual=%0d required=4", n_done); end
  endtask

  task automatic test_reset_abort();
    int wait_cnt, done_seen, lat, gaps;
    bit to;
    logic [6:0] exp;
    tb_mode = M_XOR;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cnt = 0;
    while (!(probe_a === 1'b1 && probe_b === 1'b0) && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    checks++; if (wait_cnt >= 50) begin failures++; $display("[TB] FAIL abort_reach_index2 actual=timeout required=index2"); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({probe_a, probe_b, busy, done} !== 4'b0000) begin failures++; $display("[TB] FAIL abort_ctrl actual=%b required=0000", {probe_a, probe_b, busy, done}); end
    checks++; if (truth_table !== 4'b0000 || gate_code !== 3'd0 || result_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_results actual=%b/%0d/%b required=0000/0/0", truth_table, gate_code, result_valid); end
    done_seen = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    checks++; if (done_seen != 0) begin failures++; $display("[TB] FAIL abort_no_done actual=%0d required=0", done_seen); end
    tb_mode = M_XNOR;
    sb.push_back({model_table(M_XNOR), 3'd7});
    start_and_wait(lat, to, gaps);
    exp = sb.pop_front();
    checks++; if (to || lat != 4 * (SETTLE + 1) || truth_table !== exp[6:3] || gate_code !== exp[2:0] || result_valid !== 1'b1) begin failures++; $display("[TB] FAIL abort_fresh_run actual=%0d:%b/%0d required=%0d:%b/%0d", lat, truth_table, gate_code, 4 * (SETTLE + 1), exp[6:3], exp[2:0]); end
  endtask

  task automatic test_reset_start();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checks++; if (busy !== 1'b0 || {probe_a, probe_b} !== 2'b00) begin failures++; $display("[TB] FAIL rst_start_busy actual=%b required=0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL rst_start_idle actual=%b%b required=00", busy, done); end
  endtask

  initial begin
    $display("[TB] gate_identifier bench starting");
    test_reset();
    test_and();
    test_back_to_back();
    test_not_and_const();
    test_start_held();
    test_reset_abort();
    test_reset_start();
    checks++; if (sb.size() != 0 || sb0.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_drain actual=%0d/%0d required=0/0", sb.size(), sb0.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
